// File: rtl/edge_pkg.sv
// Shared constants and types for the edge-detection front end.
package edge_pkg;

   localparam int unsigned STRIP_LEN = 20;
   localparam int unsigned OUT_LEN   = 16;
   localparam int unsigned TAPS      = 5;

   typedef logic [7:0] pixel_t;

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      FETCH   = 3'd1,
      PRESENT = 3'd2,
      HOLD    = 3'd3,
      DONE    = 3'd4
   } fetch_state_type;

endpackage

// File: rtl/flex_counter.sv
// Up-counter with synchronous clear that wraps to zero after reaching rollover_val.
module flex_counter #(
   parameter int unsigned NUM_CNT_BITS = 4
) (
   input  logic                    clk,
   input  logic                    n_rst,
   input  logic                    clear,
   input  logic                    count_enable,
   input  logic [NUM_CNT_BITS-1:0] rollover_val,
   output logic [NUM_CNT_BITS-1:0] count_out,
   output logic                    rollover_flag
);

   logic [NUM_CNT_BITS-1:0] count_q, count_d;

   always_comb begin
      count_d = count_q;
      if (clear) begin
         count_d = '0;
      end else if (count_enable) begin
         count_d = (count_q == rollover_val) ? '0 : count_q + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (!n_rst) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   assign count_out     = count_q;
   assign rollover_flag = (count_q == rollover_val);

endmodule

// File: rtl/window_fetcher.sv
// Fetches 20-row vertical pixel strips column by column and presents them to a blur stage.
// WINDOW_FETCHER_BORDER_CLAMP_EN: clamp out-of-image rows instead of substituting zero.
module window_fetcher
   import edge_pkg::*;
#(
   parameter int unsigned IMG_WIDTH  = 640,
   parameter int unsigned IMG_HEIGHT = 480,
   parameter logic [31:0] BASE_ADDR  = 32'd0
) (
   input  logic                          clk,
   input  logic                          n_rst,
   input  logic                          start,
   output logic [31:0]                   mem_addr,
   output logic                          mem_read,
   input  logic [7:0]                    mem_rdata,
   input  logic                          mem_ready,
   output logic                          anchor_moving,
   output logic [31:0]                   anchor_x,
   output logic [31:0]                   anchor_y,
   output logic [STRIP_LEN-1:0][7:0]     blur_in,
   input  logic                          blur_final,
   output logic                          frame_done
);

   localparam logic [31:0]        X_LAST   = 32'(IMG_WIDTH - 1);
   localparam logic [31:0]        Y_LAST   = 32'(IMG_HEIGHT - OUT_LEN);
   localparam logic signed [32:0] HEIGHT_S = 33'(IMG_HEIGHT);

   fetch_state_type state_q, state_d;
   logic [31:0] ax_q, ax_d, ay_q, ay_d;
   logic [STRIP_LEN-1:0][7:0] stage_q, stage_d, blur_q, blur_d;

   logic [4:0]         k;
   logic               k_last;
   logic signed [32:0] row_raw;
   logic [31:0]        row_eff;
   logic               in_range, rd_ok, step;
   pixel_t             pix;

   // Row relative to the strip anchor; two rows of context above the first output row.
   assign row_raw  = $signed({1'b0, ay_q}) + $signed({28'd0, k}) - 33'sd2;
   assign in_range = !row_raw[32] && (row_raw < HEIGHT_S);

`ifdef WINDOW_FETCHER_BORDER_CLAMP_EN
   always_comb begin
      if (row_raw[32]) begin
         row_eff = '0;
      end else if (!in_range) begin
         row_eff = 32'(IMG_HEIGHT - 1);
      end else begin
         row_eff = row_raw[31:0];
      end
   end
   assign rd_ok = 1'b1;
`else
   assign row_eff = row_raw[31:0];
   assign rd_ok   = in_range;
`endif

   assign mem_read = (state_q == FETCH) && rd_ok;
   assign mem_addr = mem_read ? (BASE_ADDR + row_eff * 32'(IMG_WIDTH) + ax_q) : 32'd0;
   // Skipped rows advance immediately and contribute a zero pixel.
   assign step     = (state_q == FETCH) && (!mem_read || mem_ready);
   assign pix      = mem_read ? mem_rdata : 8'd0;

   flex_counter #(
      .NUM_CNT_BITS (5)
   ) u_k_cnt (
      .clk           (clk),
      .n_rst         (n_rst),
      .clear         (state_q == IDLE),
      .count_enable  (step),
      .rollover_val  (5'(STRIP_LEN - 1)),
      .count_out     (k),
      .rollover_flag (k_last)
   );

   always_comb begin
      state_d = state_q;
      ax_d    = ax_q;
      ay_d    = ay_q;
      stage_d = stage_q;
      blur_d  = blur_q;
      case (state_q)
         IDLE: begin
            if (start) begin
               state_d = FETCH;
               ax_d    = '0;
               ay_d    = '0;
            end
         end
         FETCH: begin
            if (step) begin
               stage_d[k] = pix;
               if (k_last) begin
                  blur_d  = stage_d;
                  state_d = PRESENT;
               end
            end
         end
         PRESENT: state_d = HOLD;
         HOLD: begin
            if (blur_final) begin
               if (ax_q != X_LAST) begin
                  ax_d    = ax_q + 32'd1;
                  state_d = FETCH;
               end else if (ay_q != Y_LAST) begin
                  ax_d    = '0;
                  ay_d    = ay_q + 32'(OUT_LEN);
                  state_d = FETCH;
               end else begin
                  state_d = DONE;
               end
            end
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!n_rst) begin
         state_q <= IDLE;
         ax_q    <= '0;
         ay_q    <= '0;
         stage_q <= '0;
         blur_q  <= '0;
      end else begin
         state_q <= state_d;
         ax_q    <= ax_d;
         ay_q    <= ay_d;
         stage_q <= stage_d;
         blur_q  <= blur_d;
      end
   end

   assign anchor_moving = (state_q == PRESENT);
   assign frame_done    = (state_q == DONE);
   assign anchor_x      = ax_q;
   assign anchor_y      = ay_q;
   assign blur_in       = blur_q;

endmodule

// File: tb/tb_window_fetcher.sv
// Directed bench for window_fetcher on a 4x32 image with mem[a] = a[7:0].
module tb_window_fetcher;

   localparam int W = 4;
   localparam int H = 32;

   logic              clk = 1'b0;
   logic              n_rst = 1'b0;
   logic              start = 1'b0;
   logic [31:0]       mem_addr;
   logic              mem_read;
   logic [7:0]        mem_rdata;
   logic              mem_ready;
   logic              anchor_moving;
   logic [31:0]       anchor_x, anchor_y;
   logic [19:0][7:0]  blur_in;
   logic              blur_final = 1'b0;
   logic              frame_done;

   logic              stall_mode = 1'b0;
   int                wait_cnt = 0;
   int                checks = 0;
   int                errors = 0;

   typedef struct {
      int ax;
      int ay;
   } strip_t;
   strip_t strips [8];

   window_fetcher #(
      .IMG_WIDTH  (W),
      .IMG_HEIGHT (H),
      .BASE_ADDR  (32'd0)
   ) dut (
      .clk           (clk),
      .n_rst         (n_rst),
      .start         (start),
      .mem_addr      (mem_addr),
      .mem_read      (mem_read),
      .mem_rdata     (mem_rdata),
      .mem_ready     (mem_ready),
      .anchor_moving (anchor_moving),
      .anchor_x      (anchor_x),
      .anchor_y      (anchor_y),
      .blur_in       (blur_in),
      .blur_final    (blur_final),
      .frame_done    (frame_done)
   );

   always #5 clk = ~clk;

   // Memory: three wait cycles per read when stalling.
   assign mem_rdata = mem_addr[7:0];
   assign mem_ready = stall_mode ? (wait_cnt == 3) : 1'b1;
   always @(posedge clk) begin
      if (!mem_read || mem_ready) wait_cnt <= 0;
      else wait_cnt <= wait_cnt + 1;
   end

   function automatic bit exp_read(int ay, int k);
      int r = ay - 2 + k;
`ifdef WINDOW_FETCHER_BORDER_CLAMP_EN
      return 1'b1;
`else
      return (r >= 0) && (r < H);
`endif
   endfunction

   function automatic logic [31:0] exp_addr(int ax, int ay, int k);
      int r = ay - 2 + k;
      if (r < 0) r = 0;
      if (r > H - 1) r = H - 1;
      return 32'(r * W + ax);
   endfunction

   function automatic logic [159:0] exp_blur(int ax, int ay);
      logic [31:0]  a;
      logic [159:0] v = '0;
      for (int k = 0; k < 20; k++) begin
         a = exp_addr(ax, ay, k);
         if (exp_read(ay, k)) v[k*8 +: 8] = a[7:0];
      end
      return v;
   endfunction

   function automatic int exp_lat(int ay, bit stall);
      int n = 1;
      for (int k = 0; k < 20; k++) n += (exp_read(ay, k) && stall) ? 4 : 1;
      return n;
   endfunction

   task automatic check(input string name, input logic [159:0] act, input logic [159:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic check_reset_state();
      check("rst_mem_read", 160'(mem_read), 160'(0));
      check("rst_mem_addr", 160'(mem_addr), 160'(0));
      check("rst_anchor_moving", 160'(anchor_moving), 160'(0));
      check("rst_frame_done", 160'(frame_done), 160'(0));
      check("rst_anchor_x", 160'(anchor_x), 160'(0));
      check("rst_anchor_y", 160'(anchor_y), 160'(0));
      check("rst_blur_in", blur_in, 160'(0));
   endtask

   // Waits for anchor_moving; the cycle in which start/blur_final was driven is cycle 0.
   task automatic wait_present(input int ax, input int ay, input bit stall, input bit inject,
                               output int cyc);
      bit          last_stall = 1'b0;
      logic [31:0] last_addr = '0;
      cyc = 0;
      while (cyc < 200) begin
         @(negedge clk);
         cyc++;
         start      = 1'b0;
         blur_final = 1'b0;
         if (anchor_moving) break;
         check("no_frame_done_in_fetch", 160'(frame_done), 160'(0));
         if (!stall && cyc <= 20) begin
            check("mem_read", 160'(mem_read), 160'(exp_read(ay, cyc - 1)));
            if (exp_read(ay, cyc - 1))
               check("mem_addr", 160'(mem_addr), 160'(exp_addr(ax, ay, cyc - 1)));
         end
         if (last_stall) begin
            check("stall_read_held", 160'(mem_read), 160'(1));
            check("stall_addr_stable", 160'(mem_addr), 160'(last_addr));
         end
         last_stall = mem_read && !mem_ready;
         last_addr  = mem_addr;
         if (inject && cyc == 5) begin
            start      = 1'b1;
            blur_final = 1'b1;
         end
         if (inject && cyc == 6) begin
            check("inject_anchor_x", 160'(anchor_x), 160'(ax));
            check("inject_anchor_y", 160'(anchor_y), 160'(ay));
         end
      end
      if (!anchor_moving) begin
         errors++;
         $display("FAIL anchor_moving_timeout: got none expected pulse within 200 cycles");
      end
   endtask

   task automatic run_frame(input int n_strips, input bit stall, input bit inject);
      int cyc;
      stall_mode = stall;
      @(negedge clk);
      start = 1'b1;
      for (int s = 0; s < n_strips; s++) begin
         wait_present(strips[s].ax, strips[s].ay, stall, inject && (s == 1), cyc);
         check("latency", 160'(cyc), 160'(exp_lat(strips[s].ay, stall)));
         check("anchor_x", 160'(anchor_x), 160'(strips[s].ax));
         check("anchor_y", 160'(anchor_y), 160'(strips[s].ay));
         check("blur_in", blur_in, exp_blur(strips[s].ax, strips[s].ay));
         if (s == 0) begin
            check("blur_in0", 160'(blur_in[0]), 160'(0));
            check("blur_in2", 160'(blur_in[2]), 160'(0));
            check("blur_in3", 160'(blur_in[3]), 160'(4));
            if (!stall) check("first_latency", 160'(cyc), 160'(21));
         end
         if (s == n_strips - 1 && n_strips < 8) break;
         for (int h = 1; h <= 5; h++) begin
            @(negedge clk);
            check("hold_no_move", 160'(anchor_moving), 160'(0));
            check("hold_blur_in", blur_in, exp_blur(strips[s].ax, strips[s].ay));
            check("hold_no_done", 160'(frame_done), 160'(0));
         end
         blur_final = 1'b1;
      end
      if (n_strips == 8) begin
         @(negedge clk);
         blur_final = 1'b0;
         check("frame_done_pulse", 160'(frame_done), 160'(1));
         @(negedge clk);
         check("frame_done_clear", 160'(frame_done), 160'(0));
         check("idle_no_read", 160'(mem_read), 160'(0));
      end
      stall_mode = 1'b0;
   endtask

   initial begin
      int cyc;
      for (int i = 0; i < 8; i++) begin
         strips[i].ax = i % 4;
         strips[i].ay = (i / 4) * 16;
      end

      n_rst = 1'b0;
      repeat (2) @(negedge clk);
      check_reset_state();
      n_rst = 1'b1;
      repeat (3) @(negedge clk);
      check("idle_stays", 160'(mem_read), 160'(0));

      run_frame(8, 1'b0, 1'b0);
      repeat (2) @(negedge clk);
      run_frame(8, 1'b1, 1'b0);
      repeat (2) @(negedge clk);
      run_frame(8, 1'b0, 1'b1);
      repeat (2) @(negedge clk);

      // Abandon a pass while holding strip (2,0), then restart.
      run_frame(3, 1'b0, 1'b0);
      repeat (2) @(negedge clk);
      n_rst = 1'b0;
      @(negedge clk);
      check_reset_state();
      n_rst = 1'b1;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         check("post_rst_no_move", 160'(anchor_moving), 160'(0));
         check("post_rst_no_done", 160'(frame_done), 160'(0));
      end
      start = 1'b1;
      wait_present(0, 0, 1'b0, 1'b0, cyc);
      check("restart_latency", 160'(cyc), 160'(21));
      check("restart_anchor_x", 160'(anchor_x), 160'(0));
      check("restart_anchor_y", 160'(anchor_y), 160'(0));
      check("restart_blur_in", blur_in, exp_blur(0, 0));

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/window_fetcher.md
WINDOW_FETCHER -- requirements
Module: window_fetcher

Interface
REQ-001 Parameters SHALL be, one per line as name, default, meaning:
- IMG_WIDTH, 640, image columns.
- IMG_HEIGHT, 480, image rows; a multiple of 16.
- BASE_ADDR, 0, byte address of pixel (0,0); row-major, 1 byte/pixel.
REQ-002 Ports SHALL be, one per line as name, direction, width, meaning:
- clk  input  1  sole clock, rising edge.
- n_rst  input  1  reset; synchronous and active-low.
- start  input  1  one-cycle pulse; begins a frame pass.
- mem_addr  output  32  pixel read address.
- mem_read  output  1  read request.
- mem_rdata  input  8  read data.
- mem_ready  input  1  data valid for the current request.
- anchor_moving  output  1  one-cycle pulse; blur_in holds a new strip.
- anchor_x  output  32  strip column.
- anchor_y  output  32  first output row of strip.
- blur_in  output  8 x 20  strip pixels; element k is row anchor_y-2+k.
- blur_final  input  1  consumer finished the current strip.
- frame_done  output  1  one-cycle pulse after the last strip completes.

Function
REQ-003 The FSM SHALL have states IDLE, FETCH, PRESENT, HOLD, DONE.
REQ-004 IDLE SHALL go to FETCH when start=1, with anchor_x=0, anchor_y=0 and pixel index k=0; otherwise it stays in IDLE.
REQ-005 In FETCH the block SHALL drive mem_read=1 and mem_addr=BASE_ADDR+row*IMG_WIDTH+anchor_x, where row = anchor_y-2+k after border handling.
REQ-006 A read SHALL complete on a cycle with mem_read=1 and mem_ready=1: mem_rdata is written into a staging buffer at index k, then k increments. mem_addr SHALL stay stable while mem_ready=0.
REQ-007 When the read at k=19 completes, the FSM SHALL go to PRESENT.
REQ-008 PRESENT SHALL last one cycle: copy the staging buffer into blur_in, assert anchor_moving=1, then go to HOLD.
REQ-009 blur_in, anchor_x and anchor_y SHALL stay constant from the PRESENT cycle until the next PRESENT cycle.
REQ-010 HOLD SHALL wait for blur_final=1, then advance the anchor:
- if anchor_x < IMG_WIDTH-1: anchor_x+1;
- else: anchor_x=0 and anchor_y+16.
REQ-011 After advancing, the FSM SHALL go to FETCH with k=0.
REQ-012 If blur_final=1 arrives with anchor_x=IMG_WIDTH-1 and anchor_y=IMG_HEIGHT-16, the FSM SHALL go to DONE. DONE SHALL pulse frame_done for one cycle, then return to IDLE.
REQ-013 start SHALL be ignored outside IDLE.
REQ-014 blur_final SHALL be ignored outside HOLD.
REQ-015 mem_ready SHALL be ignored while mem_read=0.
REQ-016 Fetch latency per strip SHALL be 20 cycles plus memory wait cycles. Presentation SHALL occur on the cycle after the final read completes.
REQ-017 Address arithmetic SHALL be 32-bit unsigned. Row computation SHALL use signed 33-bit values before border handling.

Reset
REQ-018 With n_rst=0 at a rising edge, the block SHALL reach state IDLE and set:
- anchor_x=0, anchor_y=0, k=0;
- mem_read=0, mem_addr=0;
- anchor_moving=0, frame_done=0;
- all blur_in elements=0.
REQ-019 Reset asserted mid-FETCH or mid-HOLD SHALL abandon the pass: no anchor_moving or frame_done pulse, and an outstanding read is dropped.

Configuration
REQ-020 The macro WINDOW_FETCHER_BORDER_CLAMP_EN SHALL select border handling.
- Defined: a row < 0 reads row 0; a row > IMG_HEIGHT-1 reads row IMG_HEIGHT-1.
- Undefined: an out-of-range row issues no read (mem_read=0), loads 0 into the staging buffer, and k advances in one cycle.

Structure
REQ-021 Package edge_pkg SHALL hold:
- STRIP_LEN=20, OUT_LEN=16, TAPS=5;
- the fetch_state_type enum;
- the pixel_t 8-bit typedef.
REQ-022 The pixel index k SHALL use a flex_counter instance with rollover value 19. Anchor counters SHALL be local registers.

Verification
REQ-023 IMG_WIDTH=4, IMG_HEIGHT=32, mem[a]=a[7:0], clamp enabled, mem_ready always 1, start pulse:
- first anchor_moving 21 cycles after start;
- blur_in[0..2]=0,0,0 and blur_in[3]=4.
REQ-024 Same setup, with blur_final returned 5 cycles after each anchor_moving:
- exactly 8 anchor_moving pulses;
- anchor (3,16) last;
- frame_done one cycle after the 8th blur_final.
REQ-025 mem_ready low 3 cycles on every read:
- 80 cycles of fetch per strip;
- mem_addr stable during each stall;
- identical blur_in contents to REQ-023.
REQ-026 Clamp macro undefined, anchor (0,0):
- no read issued for k=0,1;
- blur_in[0]=blur_in[1]=0;
- blur_in[2]=mem[0].
REQ-027 Reset pulled low during HOLD of anchor (2,0), then start:
- next anchor_moving at anchor (0,0);
- no frame_done before that.
REQ-028 start pulsed during FETCH and blur_final pulsed during FETCH:
- no state change;
- anchor unchanged;
- the sequence completes as in REQ-024.
